conv_tile_ctrl: RTL

Parametrised successor to the single-tile convolution top: it sequences one output tile through the Conv_Loop1 engine array. Per beat it fetches pixel/weight words from BRAM, accumulates over NIF input maps, captures the Piy×Pix accumulator block into an output holding register, and drains it to BRAM over a ready/valid handshake with backpressure. Tile length, map count, lane geometry and address stride are parameters. Read and write address generators are independent.

---
 rtl/conv_tile_pkg.sv | 25 ++
 rtl/conv_tile_out_reg.sv | 72 +++++++
 rtl/conv_tile_ctrl.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/conv_tile_pkg.sv
// Shared types and default geometry for the convolution tile controller.
// Consumers: conv_tile_ctrl (top) and conv_tile_out_reg.
package conv_tile_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LOAD,
        RUN,
        WAIT_OUT,
        DONE
    } conv_tile_state_t;

    localparam int CONV_RES       = 8;
    localparam int CONV_PIX       = 4;
    localparam int CONV_PIY       = 4;
    localparam int CONV_NIF       = 4;
    localparam int CONV_ADDR_STEP = 4;

    // Counter width for a count of n, never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/conv_tile_out_reg.sv
// Output holding register, pending register, optional ReLU and write-address counter.
// Optional feature: define CONV_TILE_RELU_EN to clamp negative lanes to zero at capture.
module conv_tile_out_reg
    import conv_tile_pkg::*;
#(
    parameter int RES       = CONV_RES,
    parameter int PIX       = CONV_PIX,
    parameter int PIY       = CONV_PIY,
    parameter int ADDR_W    = 32,
    parameter int ADDR_STEP = CONV_ADDR_STEP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cap_acc,
    input  logic                    cap_pend,
    input  logic                    pend_latch,
    input  logic                    wr_addr_clr,
    input  logic [PIY*PIX*RES-1:0]  eng_acc,
    input  logic                    out_ready,
    output logic                    slot_free,
    output logic [PIY*PIX*RES-1:0]  out_pixels,
    output logic                    out_valid,
    output logic                    write_en,
    output logic [ADDR_W-1:0]       bram_wr_addr
);

    localparam int LANES     = PIY * PIX;
    localparam int LANE_BITS = LANES * RES;
    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(ADDR_STEP);

    function automatic logic [LANE_BITS-1:0] relu_block(input logic [LANE_BITS-1:0] blk);
`ifdef CONV_TILE_RELU_EN
        logic [LANE_BITS-1:0] res;
        logic signed [RES-1:0] lane;
        res = blk;
        for (int k = 0; k < LANES; k++) begin
            lane = blk[k*RES +: RES];
            if (lane < 0) res[k*RES +: RES] = '0;
        end
        return res;
`else
        return blk;
`endif
    endfunction

    logic [LANE_BITS-1:0] pend_p0;
    logic [LANE_BITS-1:0] cap_src;
    logic                 load;

    assign write_en  = out_valid & out_ready;
    assign slot_free = !out_valid | out_ready;
    assign load      = cap_acc | cap_pend;
    assign cap_src   = cap_pend ? pend_p0 : eng_acc;

    // A load and an accept in the same cycle keep out_valid high with the new block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend_p0      <= '0;
            out_pixels   <= '0;
            out_valid    <= 1'b0;
            bram_wr_addr <= '0;
        end else begin
            if (pend_latch) pend_p0 <= eng_acc;
            if (load) out_pixels <= relu_block(cap_src);
            if (load)          out_valid <= 1'b1;
            else if (write_en) out_valid <= 1'b0;
            if (wr_addr_clr)   bram_wr_addr <= '0;
            else if (write_en) bram_wr_addr <= bram_wr_addr + STEP;
        end
    end

endmodule

// File: rtl/conv_tile_ctrl.sv
// Tile sequencer: FSM, map/beat counters and read-address generator for one output tile.
// Optional feature CONV_TILE_RELU_EN is handled inside conv_tile_out_reg.
module conv_tile_ctrl
    import conv_tile_pkg::*;
#(
    parameter int RES        = CONV_RES,
    parameter int PIX        = CONV_PIX,
    parameter int PIY        = CONV_PIY,
    parameter int NIF        = CONV_NIF,
    parameter int TILE_BEATS = 16,
    parameter int ADDR_W     = 32,
    parameter int ADDR_STEP  = CONV_ADDR_STEP
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    output logic                    busy,
    output logic                    tile_done,
    output logic [ADDR_W-1:0]       bram_rd_addr,
    output logic                    read_en,
    output logic                    eng_start,
    output logic                    eng_clear,
    input  logic                    eng_done,
    input  logic [PIY*PIX*RES-1:0]  eng_acc,
    output logic [PIY*PIX*RES-1:0]  out_pixels,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    write_en,
    output logic [ADDR_W-1:0]       bram_wr_addr
);

    localparam int MAP_W  = cnt_width(NIF);
    localparam int BEAT_W = cnt_width(TILE_BEATS);
    localparam logic [MAP_W-1:0]  MAP_LAST  = MAP_W'(NIF - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TILE_BEATS - 1);
    localparam logic [ADDR_W-1:0] STEP      = ADDR_W'(ADDR_STEP);

    conv_tile_state_t  state, state_nxt;
    logic [MAP_W-1:0]  map_idx, map_idx_nxt;
    logic [BEAT_W-1:0] beat_cnt, beat_cnt_nxt;
    logic [ADDR_W-1:0] rd_addr_nxt;
    logic              slot_free, cap_acc, cap_pend, pend_latch, wr_addr_clr;
    logic              last_beat;

    assign busy      = (state != IDLE);
    assign last_beat = (beat_cnt == BEAT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            map_idx      <= '0;
            beat_cnt     <= '0;
            bram_rd_addr <= '0;
        end else begin
            state        <= state_nxt;
            map_idx      <= map_idx_nxt;
            beat_cnt     <= beat_cnt_nxt;
            bram_rd_addr <= rd_addr_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        map_idx_nxt  = map_idx;
        beat_cnt_nxt = beat_cnt;
        rd_addr_nxt  = bram_rd_addr;
        read_en      = 1'b0;
        eng_start    = 1'b0;
        eng_clear    = 1'b0;
        tile_done    = 1'b0;
        cap_acc      = 1'b0;
        cap_pend     = 1'b0;
        pend_latch   = 1'b0;
        wr_addr_clr  = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt    = FETCH;
                    map_idx_nxt  = '0;
                    beat_cnt_nxt = '0;
                    rd_addr_nxt  = '0;
                    wr_addr_clr  = 1'b1;
                end
            end
            FETCH: begin
                read_en   = 1'b1;
                state_nxt = LOAD;
            end
            LOAD: begin
                eng_start   = 1'b1;
                eng_clear   = (map_idx == '0);
                rd_addr_nxt = bram_rd_addr + STEP;
                state_nxt   = RUN;
            end
            RUN: begin
                if (eng_done) begin
                    if (map_idx != MAP_LAST) begin
                        map_idx_nxt = map_idx + 1'b1;
                        state_nxt   = FETCH;
                    end else begin
                        map_idx_nxt = '0;
                        if (slot_free) begin
                            cap_acc = 1'b1;
                            if (last_beat) state_nxt = DONE;
                            else begin
                                beat_cnt_nxt = beat_cnt + 1'b1;
                                state_nxt    = FETCH;
                            end
                        end else begin
                            // Slot still held by an unaccepted beat: park the result.
                            pend_latch = 1'b1;
                            state_nxt  = WAIT_OUT;
                        end
                    end
                end
            end
            WAIT_OUT: begin
                if (slot_free) begin
                    cap_pend = 1'b1;
                    if (last_beat) state_nxt = DONE;
                    else begin
                        beat_cnt_nxt = beat_cnt + 1'b1;
                        state_nxt    = FETCH;
                    end
                end
            end
            DONE: begin
                if (!out_valid) begin
                    tile_done   = 1'b1;
                    rd_addr_nxt = '0;
                    wr_addr_clr = 1'b1;
                    state_nxt   = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    conv_tile_out_reg #(
        .RES       (RES),
        .PIX       (PIX),
        .PIY       (PIY),
        .ADDR_W    (ADDR_W),
        .ADDR_STEP (ADDR_STEP)
    ) u_out_reg (
        .clk          (clk),
        .rst_n        (rst_n),
        .cap_acc      (cap_acc),
        .cap_pend     (cap_pend),
        .pend_latch   (pend_latch),
        .wr_addr_clr  (wr_addr_clr),
        .eng_acc      (eng_acc),
        .out_ready    (out_ready),
        .slot_free    (slot_free),
        .out_pixels   (out_pixels),
        .out_valid    (out_valid),
        .write_en     (write_en),
        .bram_wr_addr (bram_wr_addr)
    );

endmodule
